dmem_bitcount_responder: RTL and testbench
==========================================

Name: dmem_bitcount_responder

Overview:
- Memory-side responder for the single-cycle RISC-V core's data port.
- Decodes the core's store/load accesses into two regions: a word-addressed data RAM and a memory-mapped 32-bit population-count (bit counter) peripheral.
- Reads are combinational, so the core sees ReadData in the same cycle. Writes commit on the rising clock edge.
- The peripheral is sequential: a start-triggered FSM that counts set bits serially over 32 cycles and raises done/irq.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; RAM occupies byte addresses 0 .. RAM_WORDS*4-1.
- MMIO_BASE, 32'h0000_0100, base byte address of the 4-register peripheral window; must be at or above RAM_WORDS*4.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  store strobe from the core, sampled at the rising edge.
- DataAdr  in  32  byte address from the core's ALUResult; bits [1:0] ignored (word access only).
- WriteData  in  32  store data from the core.
- ReadData  out  32  combinational load data for DataAdr.
- irq  out  1  equals STATUS.done; reset value 0.

Behaviour:
- Address decode:
  - RAM hit: DataAdr < RAM_WORDS*4.
  - MMIO hit: DataAdr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped: ReadData = 0 and writes are ignored.
- RAM:
  - Asynchronous read; write on clk when MemWrite and RAM hit.
  - Contents are not cleared by reset and are undefined until written.
  - Write then read of the same address in the next cycle returns the new data.
- MMIO registers (offsets from MMIO_BASE):
  - 0x0 OPERAND: RW, reset 0.
  - 0x4 CTRL: write-only. bit0 = start, bit1 = clear_done. Reads return 0.
  - 0x8 STATUS: RO. bit0 = busy, bit1 = done, other bits 0. Reset 0.
  - 0xC RESULT: RO. bits[5:0] = count, zero-extended to 32 bits. Reset 0.
- FSM states: IDLE, COUNT, DONE (2-bit encoding). Reset state is IDLE.
- IDLE/DONE + CTRL write with bit0 = 1:
  - Load shift register with OPERAND; clear accumulator and 5-bit index.
  - Clear done, set busy, go to COUNT.
- COUNT, each cycle:
  - acc += shift[0]; shift >>= 1; index++.
  - When index == 31 in this cycle, move acc+shift[0] into RESULT, set done, clear busy, go to DONE.
- Latency: a start written at edge N gives done = 1, busy = 0 and a valid RESULT after edge N+32. RESULT holds its previous value while busy.
- Edge cases:
  - Start while busy (COUNT): ignored; the count in flight is unaffected.
  - OPERAND write during COUNT: updates OPERAND only; the count in flight uses the latched shift register.
  - CTRL bit1 = 1 in DONE: clears done, go to IDLE; RESULT retained.
  - CTRL bits0 and 1 both set: start wins (done cleared, enter COUNT).
  - Reset asserted mid-COUNT: immediately IDLE; busy, done, irq, RESULT and OPERAND = 0.
- Width rules: the accumulator is 6 bits, so a maximum of 32 fits without overflow. The index wraps naturally at 32.

Decomposition:
- Shared package dmem_bitcount_pkg holds:
  - register offsets: OFS_OPERAND = 0x0, OFS_CTRL = 0x4, OFS_STATUS = 0x8, OFS_RESULT = 0xC;
  - CTRL/STATUS bit positions;
  - FSM state typedef (IDLE, COUNT, DONE).
- One sub-module: bitcount_engine, containing the FSM, shift register, accumulator and index.
  - Inputs: clk, reset, start, clear_done, operand[31:0].
  - Outputs: busy, done, result[5:0].
- The top level contains the RAM array, address decode, OPERAND register and read mux.

Test Plan:
- Write 0xDEADBEEF to address 0x08, then read 0x08 next cycle -> ReadData = 0xDEADBEEF. Read 0x0C (never written) -> no X propagates after the bench initialises the word.
- OPERAND = 0xFFFFFFFF, CTRL = 1 at edge N:
  - STATUS = 0x1 at edges N+1 .. N+31;
  - after edge N+32: STATUS = 0x2, RESULT = 32, irq = 1.
- OPERAND = 0x80000001 -> RESULT = 2. OPERAND = 0x00000000 -> RESULT = 0, done = 1 after 32 cycles.
- Start a count of 0x0000000F, then at cycle 10 write OPERAND = 0xFFFFFFFF and CTRL = 1 -> RESULT = 4 at N+32. A fresh start afterwards -> 32.
- Assert reset at cycle 15 of a count -> STATUS = 0, RESULT = 0, irq = 0 immediately. A new start after deassert completes normally.
- In DONE, write CTRL = 2 -> done = 0, irq = 0, RESULT retained.
- Read 0x00000200 (unmapped) -> 0. A write to it leaves RAM and MMIO unchanged.

Source files
------------

// File: rtl/dmem_bitcount_pkg.sv
// +----------------------------------------------------------------------+
// | dmem_bitcount_pkg: register map, control bits and FSM state type      |
// | shared by the data-memory responder and its bit-count engine.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package dmem_bitcount_pkg;

  localparam logic [3:0] OFS_OPERAND = 4'h0;
  localparam logic [3:0] OFS_CTRL    = 4'h4;
  localparam logic [3:0] OFS_STATUS  = 4'h8;
  localparam logic [3:0] OFS_RESULT  = 4'hC;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } bc_state_t;

endpackage

`default_nettype wire

// File: rtl/bitcount_engine.sv
// +----------------------------------------------------------------------+
// | bitcount_engine: serial population counter, one operand bit per       |
// | cycle over 32 cycles, with busy/done flags and a held result.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bitcount_engine
  import dmem_bitcount_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear_done,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [5:0]  result
);

  bc_state_t   r_state;
  logic [31:0] r_shift;
  logic [5:0]  r_acc;
  logic [4:0]  r_idx;
  logic        r_busy;
  logic        r_done;
  logic [5:0]  r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // start takes priority over clear_done when both are written
          if (start) begin
            r_shift <= operand;
            r_acc   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= COUNT;
          end else if (clear_done && r_state == DONE) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        COUNT: begin
          r_acc   <= r_acc + {5'd0, r_shift[0]};
          r_shift <= {1'b0, r_shift[31:1]};
          r_idx   <= r_idx + 5'd1;
          if (r_idx == 5'd31) begin
            r_result <= r_acc + {5'd0, r_shift[0]};
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

`default_nettype wire

// File: rtl/dmem_bitcount_responder.sv
// +----------------------------------------------------------------------+
// | dmem_bitcount_responder: data-port responder with word RAM and a      |
// | memory-mapped population-count peripheral; combinational reads.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_bitcount_responder
  import dmem_bitcount_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        irq
);

  localparam int          c_aw        = $clog2(RAM_WORDS);
  localparam logic [31:0] c_ram_bytes = 32'(RAM_WORDS * 4);

  logic [31:0] r_mem [RAM_WORDS];
  logic [31:0] r_operand;
  logic        w_ram_hit;
  logic        w_mmio_hit;
  logic        w_ctrl_wr;
  logic        w_busy;
  logic        w_done;
  logic [5:0]  w_result;
  logic [31:0] w_status;
  logic        w_unused_adr;

  assign w_ram_hit    = DataAdr < c_ram_bytes;
  assign w_mmio_hit   = DataAdr[31:4] == MMIO_BASE[31:4];
  assign w_ctrl_wr    = MemWrite && w_mmio_hit && DataAdr[3:2] == OFS_CTRL[3:2];
  assign w_unused_adr = &{1'b0, DataAdr[1:0]};

  // RAM contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_hit)
      r_mem[DataAdr[c_aw+1:2]] <= WriteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_operand <= '0;
    else if (MemWrite && w_mmio_hit && DataAdr[3:2] == OFS_OPERAND[3:2])
      r_operand <= WriteData;
  end

  bitcount_engine u_engine (
    .clk       (clk),
    .reset     (reset),
    .start     (w_ctrl_wr && WriteData[CTRL_START_BIT]),
    .clear_done(w_ctrl_wr && WriteData[CTRL_CLEAR_BIT]),
    .operand   (r_operand),
    .busy      (w_busy),
    .done      (w_done),
    .result    (w_result)
  );

  always_comb begin
    w_status                  = '0;
    w_status[STATUS_BUSY_BIT] = w_busy;
    w_status[STATUS_DONE_BIT] = w_done;
  end

  always_comb begin
    ReadData = '0;
    if (w_ram_hit) begin
      ReadData = r_mem[DataAdr[c_aw+1:2]];
    end else if (w_mmio_hit) begin
      case (DataAdr[3:2])
        OFS_OPERAND[3:2]: ReadData = r_operand;
        OFS_STATUS[3:2]:  ReadData = w_status;
        OFS_RESULT[3:2]:  ReadData = {26'd0, w_result};
        default:          ReadData = '0;
      endcase
    end
  end

  assign irq = w_done;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bitcount_responder.sv
// +----------------------------------------------------------------------+
// | tb_dmem_bitcount_responder: directed stimulus with a queued           |
// | scoreboard checked by an independent negedge monitor.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dmem_bitcount_responder;

  localparam logic [31:0] BASE    = 32'h0000_0100;
  localparam logic [31:0] A_OPER  = BASE + 32'h0;
  localparam logic [31:0] A_CTRL  = BASE + 32'h4;
  localparam logic [31:0] A_STAT  = BASE + 32'h8;
  localparam logic [31:0] A_RES   = BASE + 32'hC;
  localparam logic [31:0] A_UNMAP = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        irq;

  typedef struct {
    logic [31:0] data;
    bit          chk_irq;
    logic        irq;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  bit   rd_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dmem_bitcount_responder dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Monitor: compares whatever the DUT presents against the queue head
  always @(negedge clk) begin
    if (rd_valid) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: ReadData=%h with empty scoreboard", ReadData);
      end else begin
        mon_e = q.pop_front();
        checks++;
        if (ReadData !== mon_e.data) begin
          errors++;
          $display("FAIL %s: ReadData got %h expected %h", mon_e.name, ReadData, mon_e.data);
        end
        if (mon_e.chk_irq) begin
          checks++;
          if (irq !== mon_e.irq) begin
            errors++;
            $display("FAIL %s_irq: irq got %b expected %b", mon_e.name, irq, mon_e.irq);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    #1 MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input string name,
                    input bit ci = 1'b0, input logic ei = 1'b0);
    exp_t e;
    e.data = d; e.chk_irq = ci; e.irq = ei; e.name = name;
    DataAdr = a;
    q.push_back(e);
    rd_valid = 1'b1;
    @(negedge clk);
    #1 rd_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start written at edge N; busy after N+31, done after N+32
  task automatic run_count(input logic [31:0] op, input logic [31:0] ctrl,
                           input logic [31:0] exp_cnt, input string name);
    wr(A_OPER, op);
    wr(A_CTRL, ctrl);
    tick(31);
    rd(A_STAT, 32'h1, {name, "_busy_last"});
    tick(1);
    rd(A_STAT, 32'h2, {name, "_done"}, 1'b1, 1'b1);
    rd(A_RES, exp_cnt, {name, "_result"});
  endtask

  initial begin
    tick(2);
    rd(A_STAT, 32'h0, "reset_status", 1'b1, 1'b0);
    rd(A_RES, 32'h0, "reset_result");
    rd(A_OPER, 32'h0, "reset_operand");
    @(posedge clk);
    #1 reset = 1'b0;

    // RAM write/read-back
    wr(32'h08, 32'hDEAD_BEEF);
    rd(32'h08, 32'hDEAD_BEEF, "ram_08");
    wr(32'h0C, 32'h1234_5678);
    rd(32'h0C, 32'h1234_5678, "ram_0c");
    wr(32'h00, 32'h1111_1111);
    rd(32'h00, 32'h1111_1111, "ram_00");
    rd(32'h0E, 32'h1234_5678, "ram_low_bits_ignored");
    rd(A_CTRL, 32'h0, "ctrl_reads_zero");

    // All-ones operand with per-cycle busy checks
    wr(A_OPER, 32'hFFFF_FFFF);
    rd(A_OPER, 32'hFFFF_FFFF, "operand_rw");
    wr(A_CTRL, 32'h1);
    for (int k = 0; k < 32; k++)
      rd(A_STAT, 32'h1, "ones_busy", 1'b1, 1'b0);
    rd(A_STAT, 32'h2, "ones_done", 1'b1, 1'b1);
    rd(A_RES, 32'd32, "ones_result");

    // start and clear together from DONE: start wins
    run_count(32'h0000_0000, 32'h3, 32'd0, "zero");
    run_count(32'h8000_0001, 32'h1, 32'd2, "ends");

    // Restart and operand write during COUNT are ignored by the count in flight
    wr(A_OPER, 32'h0000_000F);
    wr(A_CTRL, 32'h1);
    rd(A_RES, 32'd2, "result_held_busy");
    tick(9);
    wr(A_OPER, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    tick(20);
    rd(A_STAT, 32'h1, "f_busy_last");
    tick(1);
    rd(A_STAT, 32'h2, "f_done", 1'b1, 1'b1);
    rd(A_RES, 32'd4, "f_result");
    rd(A_OPER, 32'hFFFF_FFFF, "f_operand_updated");
    run_count(32'hFFFF_FFFF, 32'h1, 32'd32, "fresh");

    // Asynchronous reset in the middle of a count
    wr(A_OPER, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    tick(15);
    reset = 1'b1;
    rd(A_STAT, 32'h0, "rst_status", 1'b1, 1'b0);
    rd(A_RES, 32'h0, "rst_result");
    rd(A_OPER, 32'h0, "rst_operand");
    @(posedge clk);
    #1 reset = 1'b0;
    run_count(32'h0F0F_0F0F, 32'h1, 32'd16, "post_rst");

    // clear_done from DONE keeps RESULT
    wr(A_CTRL, 32'h2);
    rd(A_STAT, 32'h0, "clear_status", 1'b1, 1'b0);
    rd(A_RES, 32'd16, "clear_result");

    // Unmapped region
    rd(A_UNMAP, 32'h0, "unmapped_read");
    wr(A_UNMAP, 32'hCAFE_F00D);
    rd(A_UNMAP, 32'h0, "unmapped_after_write");
    rd(32'h00, 32'h1111_1111, "unmapped_ram00_intact");
    rd(32'h08, 32'hDEAD_BEEF, "unmapped_ram08_intact");
    rd(A_OPER, 32'h0F0F_0F0F, "unmapped_operand_intact");
    rd(A_STAT, 32'h0, "unmapped_status_intact", 1'b1, 1'b0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
